// File: rtl/freq_m_pkg.sv
// Shared types and constants for the
// frequency-measurement capture path.
package freq_m_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    COUNT,
    HOLD
  } cap_state_t;

  // Covers a 5-cycle strobe burst plus one
  // cycle of margin.
  localparam int HOLDOFF_DEF = 6;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an async input
// followed by a rising-edge detector.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Shift the input through the sync chain and
  // keep the previous synchronized level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/freq_a_capture.sv
// Counts sig_in edges between gate strobes,
// scales by time_del, hands result to reader.
module freq_a_capture
  import freq_m_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = HOLDOFF_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic             cout_b,
  input  logic [4:0]       time_del,
  input  logic             ack,
  output logic [CNT_W-1:0] freq_a,
  output logic             valid,
  output logic             overrun,
  output logic             sat
);

  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int WW = 2 * CNT_W;

  logic a_edge;
  logic s_edge;
  logic cout_b_q;

  cap_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             flag_q, flag_d;
  logic             cap;

  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_ovf;
  logic [CNT_W:0]   raw;
  logic [WW-1:0]    wide;
  logic             cap_sat;
  logic [CNT_W-1:0] cap_val;

  logic [CNT_W-1:0] freq_q, freq_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             sat_q, sat_d;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sig_in),
    .rise (a_edge)
  );

  assign s_edge = cout_b & ~cout_b_q;

  // Saturating increment; overflow is remembered
  // so the next result is flagged.
  assign cnt_ovf = a_edge & (&cnt_q);
  assign cnt_inc = (a_edge && !(&cnt_q))
                 ? cnt_q + CNT_W'(1) : cnt_q;

  // A coincident edge closes the interval.
  assign raw  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, a_edge};
  assign wide = {{(WW-CNT_W-1){1'b0}}, raw} << time_del;
  assign cap_sat = flag_q | (|wide[WW-1:CNT_W]);
  assign cap_val = cap_sat ? '1 : wide[CNT_W-1:0];

  // State, counters and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cout_b_q <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      flag_q   <= 1'b0;
      freq_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      cout_b_q <= cout_b;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      flag_q   <= flag_d;
      freq_q   <= freq_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      sat_q    <= sat_d;
    end
  end

  // Gate FSM with counter and strobe holdoff.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    flag_d  = flag_q;
    cap     = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      hold_d  = '0;
      flag_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          flag_d  = 1'b0;
          state_d = FIRST;
        end
        FIRST: begin
          cnt_d  = '0;
          flag_d = 1'b0;
          if (s_edge) begin
            cnt_d   = CNT_W'(a_edge);
            hold_d  = HW'(HOLDOFF - 1);
            state_d = HOLD;
          end
        end
        COUNT: begin
          if (s_edge) begin
            cap     = 1'b1;
            cnt_d   = CNT_W'(a_edge);
            flag_d  = 1'b0;
            hold_d  = HW'(HOLDOFF - 1);
            state_d = HOLD;
          end else begin
            cnt_d  = cnt_inc;
            flag_d = flag_q | cnt_ovf;
          end
        end
        HOLD: begin
          cnt_d  = cnt_inc;
          flag_d = flag_q | cnt_ovf;
          if (hold_q == '0) begin
            state_d = COUNT;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Result hand-off with valid/ack and overrun.
  always_comb begin
    freq_d  = freq_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    sat_d   = sat_q;
    if (cap) begin
      freq_d  = cap_val;
      sat_d   = cap_sat;
      valid_d = 1'b1;
      ovr_d   = ack ? 1'b0 : (ovr_q | valid_q);
    end else if (ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign freq_a  = freq_q;
  assign valid   = valid_q;
  assign overrun = ovr_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_freq_a_capture.sv
// Directed bench for freq_a_capture: table of
// gate scenarios plus handshake/enable sequences.
module tb_freq_a_capture;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         sig_in;
  logic         cout_b;
  logic [4:0]   time_del;
  logic         ack;
  logic [W-1:0] freq_a;
  logic         valid;
  logic         overrun;
  logic         sat;

  freq_a_capture #(
    .CNT_W(W),
    .SYNC_STAGES(2),
    .HOLDOFF(6)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .sig_in  (sig_in),
    .cout_b  (cout_b),
    .time_del(time_del),
    .ack     (ack),
    .freq_a  (freq_a),
    .valid   (valid),
    .overrun (overrun),
    .sat     (sat)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int cyc;
  int per;
  int ph;
  int glen;
  int burst;
  int ack_at;
  int rst_at;
  int en_off;
  int en_on;

  typedef struct {
    string       name;
    int          td;
    int          per;
    int          ph;
    int          glen;
    int          burst;
    int          ng;
    int          ext;
    logic [31:0] f;
    logic        v;
    logic        s;
    logic        o;
  } vec_t;

  vec_t tv[11];

  function automatic vec_t mk(
    input string nm, input int td, input int pr,
    input int p0, input int gl, input int bu,
    input int ng, input int ex, input logic [31:0] f,
    input logic v, input logic s, input logic o);
    vec_t t;
    t.name = nm; t.td = td; t.per = pr; t.ph = p0;
    t.glen = gl; t.burst = bu; t.ng = ng; t.ext = ex;
    t.f = f; t.v = v; t.s = s; t.o = o;
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm,
                         input logic [31:0] f,
                         input logic v,
                         input logic o,
                         input logic s);
    chk({nm, ".freq_a"}, freq_a, f);
    chk({nm, ".valid"}, 32'(valid), 32'(v));
    chk({nm, ".overrun"}, 32'(overrun), 32'(o));
    chk({nm, ".sat"}, 32'(sat), 32'(s));
  endtask

  task automatic start(input int td, input int pr,
                       input int p0, input int gl,
                       input int bu);
    reset    = 1'b1;
    enable   = 1'b0;
    sig_in   = 1'b0;
    cout_b   = 1'b0;
    ack      = 1'b0;
    time_del = 5'(td);
    tick;
    tick;
    reset  = 1'b0;
    cyc    = 0;
    per    = pr;
    ph     = p0;
    glen   = gl;
    burst  = bu;
    ack_at = -1;
    rst_at = -1;
    en_off = -1;
    en_on  = -1;
  endtask

  task automatic drive_to(input int last);
    int r;
    while (cyc <= last) begin
      r = cyc % glen;
      sig_in = (per != 0) && (cyc % per == ph);
      cout_b = (cyc >= glen) &&
               (r == 0 ||
                (burst != 0 && (r == 2 || r == 4)));
      ack    = (cyc == ack_at);
      reset  = (cyc == rst_at);
      enable = !(cyc >= en_off && cyc < en_on);
      tick;
      cyc++;
    end
  endtask

  initial begin
    tv[0]  = mk("first_gate", 0, 10, 0, 1000, 0, 1, 0,
                32'd0, 0, 0, 0);
    tv[1]  = mk("p10_g1000", 0, 10, 0, 1000, 0, 2, 0,
                32'd100, 1, 0, 0);
    tv[2]  = mk("td3_125", 3, 8, 0, 1000, 0, 2, 0,
                32'd1000, 1, 0, 0);
    tv[3]  = mk("td31_sat", 31, 10, 0, 20, 0, 2, 0,
                32'hFFFF_FFFF, 1, 1, 0);
    tv[4]  = mk("td30_edge", 30, 10, 0, 20, 0, 2, 0,
                32'h8000_0000, 1, 0, 0);
    tv[5]  = mk("burst2", 0, 4, 0, 200, 1, 2, 5,
                32'd50, 1, 0, 0);
    tv[6]  = mk("burst3", 0, 4, 0, 200, 1, 3, 5,
                32'd50, 1, 0, 1);
    tv[7]  = mk("coincide", 0, 10, 8, 105, 0, 2, 0,
                32'd11, 1, 0, 0);
    tv[8]  = mk("hold7", 0, 7, 0, 7, 0, 2, 0,
                32'd1, 1, 0, 0);
    tv[9]  = mk("hold6_skip", 0, 6, 0, 6, 0, 2, 0,
                32'd0, 0, 0, 0);
    tv[10] = mk("hold6_next", 0, 6, 0, 6, 0, 3, 0,
                32'd2, 1, 0, 0);

    for (int i = 0; i < 11; i++) begin
      start(tv[i].td, tv[i].per, tv[i].ph,
            tv[i].glen, tv[i].burst);
      drive_to(tv[i].ng * tv[i].glen + tv[i].ext);
      chk_out(tv[i].name, tv[i].f, tv[i].v,
              tv[i].o, tv[i].s);
    end

    // Overrun, ack-with-capture, plain ack.
    start(0, 10, 0, 1000, 0);
    chk_out("reset", 32'd0, 0, 0, 0);
    drive_to(2000);
    chk_out("ovr.g2", 32'd100, 1, 0, 0);
    per = 20;
    drive_to(3000);
    chk_out("ovr.g3", 32'd50, 1, 1, 0);
    ack_at = 4000;
    drive_to(4000);
    chk_out("ack_cap", 32'd50, 1, 0, 0);
    ack_at = 4001;
    drive_to(4001);
    chk_out("ack", 32'd50, 0, 0, 0);
    ack_at = 4002;
    drive_to(4002);
    chk_out("ack_idle", 32'd50, 0, 0, 0);

    // Enable drop, then reset, mid-interval.
    start(0, 10, 0, 100, 0);
    en_off = 250;
    en_on  = 260;
    rst_at = 450;
    drive_to(200);
    chk_out("en.g2", 32'd10, 1, 0, 0);
    drive_to(300);
    chk_out("en.discard", 32'd10, 1, 0, 0);
    drive_to(400);
    chk_out("en.resume", 32'd10, 1, 1, 0);
    drive_to(450);
    chk_out("rst.mid", 32'd0, 0, 0, 0);
    drive_to(500);
    chk_out("rst.discard", 32'd0, 0, 0, 0);
    drive_to(600);
    chk_out("rst.resume", 32'd10, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/freq_a_capture.md
# freq_a_capture

Receiving end of the gate strobe `cout_b` produced by the reference-frequency gate generator. Counts rising edges of the signal under test between consecutive gate strobes, scales the count by `time_del`, and presents the result to the Nios register interface through a valid/ack handshake. A gate burst of up to 5 cycles (N = 1/2/3 generator variants) is treated as one gate event.

## Interface
- `CNT_W`, 32: width of edge counter and result.
- `SYNC_STAGES`, 2: synchronizer depth for `sig_in`, minimum 2.
- `HOLDOFF`, 6: cycles after an accepted strobe edge during which further `cout_b` rising edges are ignored.

- `clk` in 1: system clock; `cout_b` is synchronous to it.
- `reset` in 1: reset, asynchronous, active-high; clock clk.
- `enable` in 1: measurement enable from Nios control register.
- `sig_in` in 1: signal under test, asynchronous to `clk`.
- `cout_b` in 1: gate strobe from the gate generator.
- `time_del` in 5: left-shift applied to the count; it matches the generator's right-shift of `freq_base`.
- `ack` in 1: single-cycle acknowledge from the reader.
- `freq_a` out CNT_W: scaled count of the last completed gate interval.
- `valid` out 1: `freq_a` holds an unread result.
- `overrun` out 1: sticky; a result was overwritten while unread.
- `sat` out 1: the last result saturated, either in the counter or in the shift.

## Operation
- `sig_in` passes through `SYNC_STAGES` flops, then a rising-edge detect, giving `a_edge`.
- Strobe detect: `s_edge = cout_b & ~cout_b_q`, where `cout_b_q` is `cout_b` registered once.
- FSM states:
  - IDLE: counter held at 0, strobes ignored. Goes to FIRST when `enable`=1.
  - FIRST: waits for the first `s_edge`. No capture, because the preceding interval is partial. Counter cleared to `a_edge` (0 or 1). Goes to HOLD.
  - COUNT: counter increments on `a_edge`. On `s_edge`: capture, then counter restarts at `a_edge`, then goes to HOLD.
  - HOLD: counter keeps counting; `s_edge` is ignored. A holdoff counter is loaded with HOLDOFF-1 on entry; the state returns to COUNT when the holdoff counter reaches 0.
- `enable`=0 in any state: go to IDLE next cycle and clear the counter. `freq_a`, `valid`, `overrun` and `sat` keep their values.
- Capture value:
  - Raw count = counter + `a_edge`. An edge coincident with `s_edge` belongs to the closing interval.
  - Result = raw << `time_del`, computed at 2·CNT_W width.
  - If any bit above CNT_W-1 is set, `freq_a` = all-ones and `sat`=1. Otherwise `sat`=0.
- Counter saturates at all-ones and does not wrap. It sets an internal flag that forces `sat`=1 at the next capture; the flag clears on capture.
- Handshake:
  - Capture sets `valid`.
  - `ack` with no capture in the same cycle clears `valid` and `overrun`.
  - Capture while `valid`=1 and no `ack`: overwrite `freq_a` and set `overrun`.
  - Capture and `ack` in the same cycle: `valid` stays 1, new data, `overrun` cleared and not set.
  - `ack` while `valid`=0: no effect.

## Timing
- Reset values: `freq_a`=0, `valid`=0, `overrun`=0, `sat`=0; FSM in IDLE; counter, holdoff counter, synchronizer and `cout_b_q` all 0.
- `sig_in` edge to counter increment: SYNC_STAGES+1 cycles.
- `cout_b` rising in cycle t: `freq_a` and `valid` update at the clock edge ending cycle t, so they are visible in cycle t+1.
- Strobe burst 1,0,1,0,1 (N=3 generator, 5 cycles): only the first rising edge is accepted. HOLDOFF=6 covers bursts of up to 5 cycles, plus 1 cycle of margin.
- Reset mid-operation: immediate return to reset values. No partial result is emitted.

## Structure
- Package `freq_m_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, FIRST, COUNT, HOLD} cap_state_t`;
  - the default-HOLDOFF constant.
- Sub-module `sync_edge_det` (parameters `SYNC_STAGES`; ports `clk`, `reset`, `d`, `rise`) for `sig_in`.
- Strobe detect, FSM, counter, shift/saturate and handshake stay in the top module.

## Test plan
- Single pulses, gate 1000 cycles, `sig_in` period 10 cycles, `time_del`=0:
  - first gate gives no `valid`;
  - second gate gives `freq_a`=100, `valid`=1.
- `time_del`=3, 125 edges per gate -> `freq_a`=1000.
- `time_del`=31 with count 2 -> `freq_a`=all-ones, `sat`=1.
- Strobe burst 1,0,1,0,1 every 200 cycles, `sig_in` period 4 -> exactly one capture per burst, `freq_a`=50.
- Two gates with no `ack` -> `overrun`=1, `freq_a`=latest value; then `ack` -> `valid`=0, `overrun`=0.
- Same-cycle checks:
  - `ack` coincident with capture -> `valid` stays 1, `overrun`=0.
  - `a_edge` coincident with `s_edge` -> counted in the closing interval.
- `enable` dropped mid-interval, then `reset` asserted mid-interval -> counter cleared. After `enable` returns, the first strobe is discarded; outputs hold (enable) or return to 0 (reset).
